seq_divider: RTL
================

Name: seq_divider

Overview:
- Multicycle signed integer divider implementing MIPS DIV semantics for the CPU datapath.
- Consumes operands from the A/B registers and produces the quotient for Lo and the remainder for Hi through the Lo/Hi source muxes.
- Raises a divide-by-zero flag for the control unit's exception path.
- Control unit pulses a start signal, then waits for a done pulse before writing Hi/Lo.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- div_start  in  1  start request; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (A).
- divisor  in  WIDTH  signed divisor (B).
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  divide-by-zero flag.
- quotient  out  WIDTH  signed quotient, to Lo.
- remainder  out  WIDTH  signed remainder, to Hi.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: busy=0, done=0, div_zero=0, quotient=0, remainder=0, state=IDLE, step counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE with div_start=1 and divisor≠0:
  - Latch |dividend| and |divisor| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1)).
  - Latch sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB].
  - Clear the (WIDTH+1)-bit partial remainder, set counter=WIDTH, go to CALC.
- IDLE with div_start=1 and divisor=0:
  - Go directly to DONE with div_zero=1.
  - quotient and remainder keep their previous values.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem; if non-negative, keep the difference and set quo[0]=1.
  - Decrement counter; at counter=1, go to FIX.
- FIX: negate the quotient if sign_q; negate the remainder if sign_r. Register both into the quotient/remainder outputs, then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency, with div_start sampled at edge 0:
  - Normal case: CALC during cycles 1..WIDTH, FIX at cycle WIDTH+1, done at cycle WIDTH+2 (34 for WIDTH=32).
  - Zero case: done at cycle 1.
- Semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder, modulo 2^WIDTH.
- Overflow: -2^(WIDTH-1) / -1 gives quotient=0x80000000 (wraps), remainder=0, no flag.
- div_zero: set in DONE for the zero case; cleared when the next start is accepted. It otherwise holds.
- quotient/remainder hold until the next non-zero-divisor operation completes.
- div_start while not in IDLE is ignored. No queuing.
- Operand changes after acceptance have no effect, because operands are latched.
- reset asserted mid-operation: return to IDLE on the next edge with all outputs at their reset values. No done pulse is produced.
- div_start=1 in the same cycle as reset: reset wins.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - DIV_WIDTH=32.
  - Counter width constant $clog2(WIDTH)+1.
- One natural sub-module: div_restore_step.
  - Purely combinational.
  - Inputs: rem (WIDTH+1), quo (WIDTH), divisor (WIDTH).
  - Outputs: the next rem and quo.
  - Unit-tested separately.
- The FSM, counters, sign latching and output registers live in seq_divider.

Test Plan:
- dividend=100, divisor=7, start at cycle 0 -> done only at cycle 34; quotient=14, remainder=2, div_zero=0; busy high cycles 1..34.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100/-7 -> quotient=-14, remainder=2.
- Complete 100/7, then dividend=5, divisor=0 -> done at cycle 1, div_zero=1, quotient=14 and remainder=2 unchanged. Next start of 9/3 clears div_zero; result quotient=3, remainder=0.
- dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0. Also 0/13 -> quotient=0, remainder=0.
- Start 100/7, pulse div_start with 50/5 at cycle 10 -> ignored; result is still 14 r 2 at cycle 34.
- Start 100/7, assert reset at cycle 15 -> next cycle busy=0 and all outputs 0; no done pulse. A new 9/2 start then gives 4 r 1 at +34.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider constants, state encoding and counter sizing helper
package cpu_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on {rem, quo}
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [2*WIDTH:0] cat;
    logic [WIDTH:0]   diff;
    assign cat   = {rem_i, quo_i} << 1;
    assign diff  = cat[2*WIDTH:WIDTH] - {1'b0, divisor_i};
    assign rem_o = diff[WIDTH] ? cat[2*WIDTH:WIDTH] : diff;
    assign quo_o = cat[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed divider with MIPS DIV semantics (quotient to Lo, remainder to Hi)
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = cnt_width(WIDTH);
    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d, rem_n;
    logic [WIDTH-1:0] quo_q, quo_d, quo_n, dvs_q, dvs_d, q_q, q_d, r_q, r_d;
    logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_n),
        .quo_o     (quo_n)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (div_start && divisor == '0) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end else if (div_start) begin
                    // magnitudes are unsigned, so |-2^(W-1)| fits without overflow
                    state_d = CALC;
                    dz_d    = 1'b0;
                    quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sr_d    = dividend[WIDTH-1];
                end
            end
            CALC: begin
                rem_d   = rem_n;
                quo_d   = quo_n;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? FIX : CALC;
            end
            FIX: begin
                q_d     = sq_q ? -quo_q : quo_q;
                r_d     = sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign div_zero  = dz_q;
    assign quotient  = q_q;
    assign remainder = r_q;
endmodule
